handshake_fifo_channel: RTL
===========================

# handshake_fifo_channel

Parametrised valid/ready channel that decouples a handshaking master from a handshaking slave through a DEPTH-entry first-word-fall-through FIFO. Upstream and downstream each see a standard valid/ready interface, so master and slave progress independently and back-pressure is absorbed up to DEPTH words. It replaces the direct master-to-slave wiring in the handshaking top level when the two sides run at different rates.

## Interface
- DATA_WIDTH, 8, payload width in bits (≥1)
- DEPTH, 4, FIFO entries; power of two, ≥2
- AF_THRESH, DEPTH-1, almost-full level; only used with HS_FIFO_ALMOST_FULL_EN

- clk  input  1  single clock, rising edge
- rst  input  1  asynchronous, active-low reset
- s_data  input  DATA_WIDTH  upstream payload
- s_valid  input  1  upstream word valid
- s_ready  output  1  channel can accept a word
- m_data  output  DATA_WIDTH  downstream payload (head of FIFO)
- m_valid  output  1  head word valid
- m_ready  input  1  downstream accepts head word
- count  output  $clog2(DEPTH+1)  stored words, 0..DEPTH
- almost_full  output  1  count ≥ AF_THRESH (only with HS_FIFO_ALMOST_FULL_EN)

## Operation
- Push when s_valid && s_ready at rising clk; s_data written at wr_ptr, wr_ptr += 1 mod DEPTH.
- Pop when m_valid && m_ready at rising clk; rd_ptr += 1 mod DEPTH.
- Pointers are $clog2(DEPTH) bits, wrap naturally; full/empty derived from count, not pointer compare.
- count next = count + push − pop; push and pop together leave count unchanged.
- m_valid = (count != 0); m_data = mem[rd_ptr] (FWFT, no read latency).
- s_ready = init_done && (count != DEPTH). No pass-through: when full, s_ready stays low even if m_ready is high that cycle.
- init_done: 1-bit register, 0 in reset, 1 on first clk edge after rst deasserts; gates s_ready so no word is accepted in the release cycle.
- Memory contents are not reset; m_data is don't-care while m_valid=0.
- Stability: while m_valid && !m_ready, m_data and m_valid hold. Upstream must hold s_data/s_valid while s_valid && !s_ready; channel does not check.

## Timing
- Reset (rst=0, asynchronous): count=0, wr_ptr=rd_ptr=0, m_valid=0, s_ready=0, almost_full=0, init_done=0.
- First edge after release: s_ready rises to 1 (registered). Earliest push is the second edge.
- Latency: word pushed at edge N appears on m_data with m_valid=1 after edge N (visible in cycle N+1); single-cycle fall-through minimum.
- Throughput: one push and one pop per cycle sustained when 0 < count < DEPTH.
- Empty + push + m_ready=1: word is not popped in the same cycle (m_valid was 0); pops next cycle.
- Full + pop: s_ready rises the cycle after the pop edge.
- rst asserted mid-transfer: all state cleared immediately; in-flight data discarded; no handshake completes on that edge.

## Configuration
- HS_FIFO_ALMOST_FULL_EN defined: almost_full port present, registered from next count, = (count ≥ AF_THRESH); reset 0. AF_THRESH must be 1..DEPTH.
- Undefined: port and logic absent; AF_THRESH ignored.

## Test plan
- Reset release: hold rst=0 3 cycles, release -> s_ready=0 in release cycle, 1 after next edge; m_valid=0, count=0.
- Single word: push 8'hA5 with m_ready=0 -> next cycle m_valid=1, m_data=8'hA5, count=1; assert m_ready -> count=0, m_valid=0.
- Fill/back-pressure, DEPTH=4: push 8'h01..8'h04, m_ready=0 -> count=4, s_ready=0; 5th word 8'h05 held until one pop, then accepted; output order 01,02,03,04,05.
- Wrap and concurrency: stream 20 words (8'h10..8'h23) with s_valid=1, m_ready=1 continuous -> count constant at 1 after first word, one word out per cycle, no loss or reorder across pointer wrap.
- Reset mid-operation: count=3, assert rst asynchronously between edges -> count=0, m_valid=0, s_ready=0 immediately; after release, first popped word is the first new push.
- HS_FIFO_ALMOST_FULL_EN, DEPTH=4, AF_THRESH=3: push 3 words -> almost_full=1 at count=3; pop one -> almost_full=0.

Source files
------------

// File: rtl/handshake_fifo_channel_if.sv
// handshake_fifo_channel_if: one valid/ready payload link, master drives data/valid, slave drives ready
interface handshake_fifo_channel_if #(parameter int DATA_WIDTH = 8);
  logic [DATA_WIDTH-1:0] data;
  logic                  valid;
  logic                  ready;
  modport master (output data, valid, input ready);
  modport slave  (input data, valid, output ready);
endinterface

// File: rtl/handshake_fifo_channel.sv
// handshake_fifo_channel: DEPTH-entry FWFT FIFO between two valid/ready links; HS_FIFO_ALMOST_FULL_EN adds almost_full
module handshake_fifo_channel #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4,
  parameter int AF_THRESH  = DEPTH - 1,
  localparam int CW        = $clog2(DEPTH + 1),
  localparam int PW        = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst,
  handshake_fifo_channel_if.slave  s,
  handshake_fifo_channel_if.master m,
  output logic [CW-1:0]           count
`ifdef HS_FIFO_ALMOST_FULL_EN
  , output logic                  almost_full
`endif
);
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          init_done_q;
  logic          push, pop;
  always_comb begin
    s.ready  = init_done_q && (count_q != CW'(DEPTH));
    m.valid  = count_q != '0;
    m.data   = mem_q[rd_ptr_q];
    push     = s.valid && s.ready;
    pop      = m.valid && m.ready;
    count_d  = count_q + CW'(push) - CW'(pop);
    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = rd_ptr_q + PW'(pop);
  end
  assign count = count_q;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      count_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      init_done_q <= 1'b0;
    end else begin
      count_q     <= count_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      init_done_q <= 1'b1;
    end
  // storage is left unreset; head data is only meaningful while m.valid
  always_ff @(posedge clk)
    if (push) mem_q[wr_ptr_q] <= s.data;
`ifdef HS_FIFO_ALMOST_FULL_EN
  logic almost_full_q;
  always_ff @(posedge clk or negedge rst)
    if (!rst) almost_full_q <= 1'b0;
    else      almost_full_q <= count_d >= CW'(AF_THRESH);
  assign almost_full = almost_full_q;
`endif
endmodule
